// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer slice.
// Holds the sequencer state encoding, the redirect field widths and a
// small alignment helper used by the optional alignment checker.

package pc_seq_pkg;

    // Width of the pseudo-direct jump word index field.
    localparam int JMP_IDX_W = 26;

    // Width of the signed PC-relative branch word offset.
    localparam int BR_IMM_W = 16;

    // Word offsets and indices are scaled to bytes by this shift.
    localparam int WORD_SHIFT = 2;

    // Bit position where the jump index field ends inside a 32-bit target.
    localparam int JMP_REGION_LSB = JMP_IDX_W + WORD_SHIFT;

    // Sequencer states; encoding 2'b11 is never entered and recovers to BOOT.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // True when the two byte-offset bits of an address are clear.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// pc_target_gen: combinational address arithmetic for the PC sequencer.
// Produces the sequential successor, the PC-relative branch target and the
// pseudo-direct jump target. All sums wrap modulo 2^PC_W.

import pc_seq_pkg::*;

module pc_target_gen #(
    parameter int PC_W = 32,
    parameter int INC  = 4
) (
    input  logic [PC_W-1:0]      pc,
    input  logic [PC_W-1:0]      br_base,
    input  logic [BR_IMM_W-1:0]  br_imm,
    input  logic [JMP_IDX_W-1:0] jmp_idx,
    output logic [PC_W-1:0]      pc_plus,
    output logic [PC_W-1:0]      br_target,
    output logic [PC_W-1:0]      jmp_target
);

    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    logic signed [BR_IMM_W-1:0] imm_signed;
    logic [PC_W-1:0]            imm_ext;
    logic [PC_W-1:0]            br_offset;

    // Sequential successor; the add simply drops the carry so the top of
    // the address space rolls over to zero.
    assign pc_plus = pc + INC_V;

    // The branch offset is a signed word count: sign-extend it to the PC
    // width, scale to bytes, and add to the base with wrap-around.
    assign imm_signed = br_imm;
    assign imm_ext    = PC_W'(imm_signed);
    assign br_offset  = imm_ext << WORD_SHIFT;
    assign br_target  = br_base + br_offset;

    // Jump targets keep the region bits of the successor PC above the index
    // field; narrow PCs have no region bits and take the low index bits only.
    generate
        if (PC_W >= 32) begin : g_jmp_wide
            assign jmp_target = {pc_plus[PC_W-1:JMP_REGION_LSB], jmp_idx, 2'b00};
        end else begin : g_jmp_narrow
            assign jmp_target = {jmp_idx[PC_W-3:0], 2'b00};
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register and BOOT/RUN/HALT control.
// Optional feature: define PC_ALIGN_CHECK_EN to add the misalign_fault
// output; a misaligned redirect then halts instead of loading the PC.

import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              INC       = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 br_take,
    input  logic [PC_W-1:0]      br_base,
    input  logic [BR_IMM_W-1:0]  br_imm,
    input  logic                 jmp_take,
    input  logic [JMP_IDX_W-1:0] jmp_idx,
    input  logic                 halt,
    input  logic                 resume,
    output logic [PC_W-1:0]      pc,
    output logic [PC_W-1:0]      pc_plus,
    output logic                 fetch_valid,
    output logic [1:0]           state
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                 misalign_fault
`endif
);

    pc_state_e       state_q;
    pc_state_e       state_n;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jmp_target;
    logic            redirect;
    logic            align_block;
    logic            resume_blocked;

    pc_target_gen #(
        .PC_W (PC_W),
        .INC  (INC)
    ) u_target_gen (
        .pc         (pc_q),
        .br_base    (br_base),
        .br_imm     (br_imm),
        .jmp_idx    (jmp_idx),
        .pc_plus    (pc_plus),
        .br_target  (br_target),
        .jmp_target (jmp_target)
    );

    assign redirect = jmp_take | br_take;

`ifdef PC_ALIGN_CHECK_EN
    logic [PC_W-1:0] redirect_target;
    logic            fault_q;

    // The target that would win arbitration is the one checked for alignment.
    assign redirect_target = jmp_take ? jmp_target : br_target;
    assign align_block     = (state_q == RUN) && redirect &&
                             !word_aligned(redirect_target[1:0]);

    // Once a misaligned redirect is seen the sequencer stays parked in HALT
    // until reset, so resume cannot restart execution past the fault.
    assign resume_blocked  = fault_q;
    assign misalign_fault  = fault_q;

    // Sticky fault flag; only the asynchronous reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (align_block) begin
            fault_q <= 1'b1;
        end
    end
`else
    // Without the checker every redirect target loads unchanged.
    assign align_block    = 1'b0;
    assign resume_blocked = 1'b0;
`endif

    // State register; reset forces BOOT immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; BOOT always lasts exactly one cycle, and halt with
    // resume together in HALT keeps the sequencer halted.
    always_comb begin
        state_n = state_q;
        case (state_q)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (halt || align_block) begin
                    state_n = HALT;
                end
            end
            HALT: begin
                if (resume && !halt && !resume_blocked) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    // Output logic; a redirect overrides stall, so the cycle still counts
    // as a real fetch even though the stall request is present.
    always_comb begin
        fetch_valid = 1'b0;
        if (state_q == RUN) begin
            fetch_valid = !stall || redirect;
        end
    end

    // Next-PC selection: jump beats branch beats stall beats increment.
    // A redirect taken alongside halt still loads, and HALT then holds it.
    always_comb begin
        pc_n = pc_q;
        case (state_q)
            BOOT: begin
                pc_n = RESET_VEC;
            end
            RUN: begin
                if (align_block) begin
                    pc_n = pc_q;
                end else if (jmp_take) begin
                    pc_n = jmp_target;
                end else if (br_take) begin
                    pc_n = br_target;
                end else if (stall) begin
                    pc_n = pc_q;
                end else begin
                    pc_n = pc_plus;
                end
            end
            HALT: begin
                pc_n = pc_q;
            end
            default: begin
                pc_n = RESET_VEC;
            end
        endcase
    end

    // PC register; reset discards any in-flight redirect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_n;
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// A 32-bit instance (RESET_VEC 0x00400000) covers boot, redirects, stall,
// halt/resume, misaligned targets and async reset; a 16-bit instance covers
// wrap-around. Honors PC_ALIGN_CHECK_EN when it is defined.

`timescale 1ns/1ps

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst16;
    logic        stall;
    logic        br_take;
    logic [31:0] br_base;
    logic [15:0] br_imm;
    logic        jmp_take;
    logic [25:0] jmp_idx;
    logic        halt;
    logic        resume;

    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [15:0] pc16;
    logic [15:0] pc_plus16;
    logic        fv16;
    logic [1:0]  state16;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_fault;
    logic        mf16;
`endif

    typedef struct {
        bit          sel;
        string       name;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        fv;
        logic        mf;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W      (32),
        .INC       (4),
        .RESET_VEC (32'h0040_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_take     (br_take),
        .br_base     (br_base),
        .br_imm      (br_imm),
        .jmp_take    (jmp_take),
        .jmp_idx     (jmp_idx),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .fetch_valid (fetch_valid),
        .state       (state)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    pc_sequencer #(
        .PC_W      (16),
        .INC       (4),
        .RESET_VEC (16'hFFF8)
    ) dut16 (
        .clk         (clk),
        .rst         (rst16),
        .stall       (1'b0),
        .br_take     (1'b0),
        .br_base     (16'h0000),
        .br_imm      (16'h0000),
        .jmp_take    (1'b0),
        .jmp_idx     (26'h0),
        .halt        (1'b0),
        .resume      (1'b0),
        .pc          (pc16),
        .pc_plus     (pc_plus16),
        .fetch_valid (fv16),
        .state       (state16)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_fault (mf16)
`endif
    );

    // Drive one cycle of inputs just after the rising edge and queue what the
    // outputs must show during that cycle; mid_rst pulses reset mid-cycle.
    task automatic applyStimulus(input bit sel, input string name, input logic r, input logic mid_rst,
                                 input logic s, input logic bt, input logic [31:0] bb, input logic [15:0] bi,
                                 input logic jt, input logic [25:0] ji, input logic h, input logic rs,
                                 input logic [31:0] epc, input logic [1:0] est, input logic efv, input logic emf);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel) rst16 = r;
        else     rst   = r;
        stall    = s;
        br_take  = bt;
        br_base  = bb;
        br_imm   = bi;
        jmp_take = jt;
        jmp_idx  = ji;
        halt     = h;
        resume   = rs;
        e.sel  = sel;
        e.name = name;
        e.pc   = epc;
        e.st   = est;
        e.fv   = efv;
        e.mf   = emf;
        sbq.push_back(e);
        if (mid_rst) begin
            #2;
            rst = 1'b1;
        end
    endtask

    // Compare the selected instance against one queued expectation.
    task automatic checkOutput(input exp_t e);
        logic [31:0] apc;
        logic [31:0] app;
        logic [31:0] epp;
        logic [15:0] t16;
        logic [1:0]  ast;
        logic        afv;
        logic        amf;
        amf = 1'b0;
        if (e.sel) begin
            apc = {16'h0, pc16};
            app = {16'h0, pc_plus16};
            ast = state16;
            afv = fv16;
            t16 = e.pc[15:0] + 16'd4;
            epp = {16'h0, t16};
`ifdef PC_ALIGN_CHECK_EN
            amf = mf16;
`endif
        end else begin
            apc = pc;
            app = pc_plus;
            ast = state;
            afv = fetch_valid;
            epp = e.pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
            amf = misalign_fault;
`endif
        end
        checks++;
        if (apc !== e.pc || ast !== e.st || afv !== e.fv || amf !== e.mf) begin
            failures++;
            $display("[TB] FAIL %s: got pc=%h state=%0d fv=%b mf=%b, expected pc=%h state=%0d fv=%b mf=%b",
                     e.name, apc, ast, afv, amf, e.pc, e.st, e.fv, e.mf);
        end
        checks++;
        if (app !== epp) begin
            failures++;
            $display("[TB] FAIL %s_pc_plus: got %h, expected %h", e.name, app, epp);
        end
    endtask

    // Monitor: every falling edge, pop one expectation and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                cur = sbq.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        int waited;
        rst      = 1'b1;
        rst16    = 1'b1;
        stall    = 1'b0;
        br_take  = 1'b0;
        br_base  = '0;
        br_imm   = '0;
        jmp_take = 1'b0;
        jmp_idx  = '0;
        halt     = 1'b0;
        resume   = 1'b0;

        // Boot sequence from RESET_VEC.
        applyStimulus(0, "reset_hold", 1, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd0, 0, 0);
        applyStimulus(0, "boot",       0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd0, 0, 0);
        applyStimulus(0, "run0",       0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd1, 1, 0);
        applyStimulus(0, "run1",       0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0040_0004, 2'd1, 1, 0);
        // Jump to 0x100, then jump beats branch, then negative branch to 0xFC.
        applyStimulus(0, "jmp_issue",   0, 0, 0, 0, 32'h0,   16'h0,    1, 26'h40, 0, 0, 32'h0040_0008, 2'd1, 1, 0);
        applyStimulus(0, "jmp_over_br", 0, 0, 0, 1, 32'h104, 16'hFFFE, 1, 26'h40, 0, 0, 32'h0000_0100, 2'd1, 1, 0);
        applyStimulus(0, "br_neg",      0, 0, 0, 1, 32'h104, 16'hFFFE, 0, 26'h0,  0, 0, 32'h0000_0100, 2'd1, 1, 0);
        applyStimulus(0, "br_landed",   0, 0, 0, 0, 32'h0,   16'h0,    0, 26'h0,  0, 0, 32'h0000_00FC, 2'd1, 1, 0);
        applyStimulus(0, "jmp_to_20",   0, 0, 0, 0, 32'h0,   16'h0,    1, 26'h8,  0, 0, 32'h0000_0100, 2'd1, 1, 0);
        // Three stalled cycles at 0x20, then a branch to 0x80 overriding stall.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, $sformatf("stall%0d", i), 0, 0, 1, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0020, 2'd1, 0, 0);
        end
        applyStimulus(0, "stall_br",      0, 0, 1, 1, 32'h70, 16'h4, 0, 26'h0, 0, 0, 32'h0000_0020, 2'd1, 1, 0);
        applyStimulus(0, "br_over_stall", 0, 0, 0, 0, 32'h0,  16'h0, 0, 26'h0, 0, 0, 32'h0000_0080, 2'd1, 1, 0);
        // Halt with a same-cycle branch to 0x200; redirects ignored while halted.
        applyStimulus(0, "halt_br", 0, 0, 0, 1, 32'h1FC, 16'h1, 0, 26'h0, 1, 0, 32'h0000_0084, 2'd1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, $sformatf("halt_hold%0d", i), 0, 0, 1, 1, 32'h300, 16'h0, 1, 26'h99, 0, 0, 32'h0000_0200, 2'd2, 0, 0);
        end
        applyStimulus(0, "halt_and_resume", 0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 1, 1, 32'h0000_0200, 2'd2, 0, 0);
        applyStimulus(0, "halt_resume",     0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 1, 32'h0000_0200, 2'd2, 0, 0);
        applyStimulus(0, "resumed",         0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0200, 2'd1, 1, 0);
        applyStimulus(0, "resumed_inc",     0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0204, 2'd1, 1, 0);
        // Misaligned branch target 0x102.
        applyStimulus(0, "misalign_issue",  0, 0, 0, 1, 32'h102, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0208, 2'd1, 1, 0);
`ifdef PC_ALIGN_CHECK_EN
        applyStimulus(0, "misalign_fault",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 1, 32'h0000_0208, 2'd2, 0, 1);
        applyStimulus(0, "fault_sticky",    0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 1, 32'h0000_0208, 2'd2, 0, 1);
`else
        applyStimulus(0, "misalign_load",   0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0102, 2'd1, 1, 0);
        applyStimulus(0, "misalign_run",    0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0106, 2'd1, 1, 0);
`endif
        // Asynchronous reset mid-cycle during a pending branch, then reboot.
        applyStimulus(0, "async_rst",   0, 1, 0, 1, 32'h500, 16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd0, 0, 0);
        applyStimulus(0, "rst_held",    1, 0, 0, 0, 32'h0,   16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd0, 0, 0);
        applyStimulus(0, "rst_boot",    0, 0, 0, 0, 32'h0,   16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd0, 0, 0);
        applyStimulus(0, "rst_run",     0, 0, 0, 0, 32'h0,   16'h0, 0, 26'h0, 0, 0, 32'h0040_0000, 2'd1, 1, 0);
        // 16-bit instance: increment wraps from 0xFFFC to 0x0000.
        applyStimulus(1, "w16_reset", 1, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_FFF8, 2'd0, 0, 0);
        applyStimulus(1, "w16_boot",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_FFF8, 2'd0, 0, 0);
        applyStimulus(1, "w16_run0",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_FFF8, 2'd1, 1, 0);
        applyStimulus(1, "w16_run1",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_FFFC, 2'd1, 1, 0);
        applyStimulus(1, "w16_wrap",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0000, 2'd1, 1, 0);
        applyStimulus(1, "w16_run3",  0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 0, 32'h0000_0004, 2'd1, 1, 0);

        // Wait, bounded, for the monitor to consume every expectation.
        waited = 0;
        while (sbq.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 32, PC and address width in bits (legal 16..64).
REQ-002 Parameter INC, default 4, sequential increment in bytes (power of two, less than 2^PC_W).
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port stall  in  1  hold PC, issue nothing new.
REQ-007 Port br_take  in  1  take PC-relative branch this cycle.
REQ-008 Port br_base  in  PC_W  branch base (PC+INC of the branch instruction).
REQ-009 Port br_imm  in  16  signed word offset.
REQ-010 Port jmp_take  in  1  take pseudo-direct jump.
REQ-011 Port jmp_idx  in  26  jump word index.
REQ-012 Port halt  in  1  enter HALT state.
REQ-013 Port resume  in  1  leave HALT state.
REQ-014 Port pc  out  PC_W  current fetch PC, registered.
REQ-015 Port pc_plus  out  PC_W  pc+INC, combinational from pc.
REQ-016 Port fetch_valid  out  1  pc is a real fetch this cycle.
REQ-017 Port state  out  2  encoded FSM state.

Function
REQ-018 FSM states SHALL be BOOT=0, RUN=1, HALT=2; encoding 3 is unreachable and SHALL decode to BOOT on the next edge.
REQ-019 BOOT SHALL last exactly one cycle after reset release, hold pc=RESET_VEC, drive fetch_valid=0, then go to RUN.
REQ-020 In RUN, next pc priority SHALL be: jmp_take > br_take > stall (hold) > pc_plus.
REQ-021 Branch target SHALL be br_base + (sign-extend(br_imm) << 2), truncated to PC_W, wrapping modulo 2^PC_W.
REQ-022 Jump target SHALL be {pc_plus[PC_W-1:28], jmp_idx, 2'b00}; for PC_W<32, SHALL be {jmp_idx,2'b00} truncated to PC_W.
REQ-023 Redirect (jmp_take or br_take) SHALL override stall in the same cycle; the target is loaded at the next edge.
REQ-024 fetch_valid SHALL be 1 in RUN when stall=0, and 0 in BOOT, HALT, or while stalled without redirect.
REQ-025 Sequential increment SHALL wrap from 2^PC_W-INC to 0 without any flag.
REQ-026 halt in RUN SHALL move to HALT at the next edge; a same-cycle redirect SHALL still load pc, and that target is held.
REQ-027 In HALT, pc SHALL hold, redirects and stall SHALL be ignored, and resume SHALL return to RUN at the next edge; simultaneous halt and resume in HALT SHALL stay HALT.
REQ-028 Redirect-to-pc latency SHALL be exactly 1 cycle; no internal queueing of redirects.

Reset
REQ-029 rst assertion SHALL immediately set pc=RESET_VEC, state=BOOT, fetch_valid=0, and misalign_fault=0 when present, regardless of clk.
REQ-030 Reset asserted mid-redirect or in HALT SHALL discard all pending state; no redirect survives reset.

Configuration
REQ-031 Macro PC_ALIGN_CHECK_EN SHALL add output misalign_fault (1 bit).
REQ-032 With PC_ALIGN_CHECK_EN, a redirect target with bits [1:0]!=0 SHALL set misalign_fault sticky, move to HALT, and not load pc; only rst clears it.
REQ-033 Without PC_ALIGN_CHECK_EN, the port SHALL be absent and misaligned targets SHALL load unchanged.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum (BOOT/RUN/HALT) and constants JMP_IDX_W=26 and BR_IMM_W=16.
REQ-035 One sub-module, pc_target_gen, SHALL compute pc_plus, the branch target and the jump target combinationally; the FSM and pc register stay in pc_sequencer.

Verification
REQ-036 Reset release with RESET_VEC=0x00400000 -> 1 cycle of BOOT with fetch_valid=0, then pc 0x00400000, 0x00400004, 0x00400008 with fetch_valid=1.
REQ-037 pc=0x100, br_take=1, br_base=0x104, br_imm=-2 -> next pc=0x0FC; same cycle with jmp_take=1, jmp_idx=0x40 -> next pc=0x100 (jump wins).
REQ-038 stall=1 for 3 cycles at pc=0x20 -> pc holds 0x20 and fetch_valid=0; br_take during the stall with target 0x80 -> pc=0x80 next cycle.
REQ-039 PC_W=16, pc=0xFFFC, no redirect -> next pc=0x0000.
REQ-040 halt with simultaneous br_take to 0x200 -> state=HALT and pc=0x200 held for 5 cycles despite further redirects; resume -> RUN, pc=0x204 one cycle later.
REQ-041 With PC_ALIGN_CHECK_EN, br_base=0x102, br_imm=0 -> misalign_fault=1, state=HALT, pc unchanged; async rst mid-cycle clears all outputs immediately.
